// File: rtl/fpu_pkg.sv
// fpu_pkg: binary32 constants, divider state type and iteration count (FDIV_ROUND_EN adds a guard iteration)
package fpu_pkg;
  localparam int FP_BIAS = 127;
  localparam int FP_EXP_W = 8;
  localparam int FP_FRAC_W = 23;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam logic [30:0] FP_INF = 31'h7F800000;
  typedef enum logic [1:0] {IDLE, DIV, DONE} fdiv_state_t;
`ifdef FDIV_ROUND_EN
  localparam int FDIV_ITER = 26;
`else
  localparam int FDIV_ITER = 25;
`endif
endpackage

// File: rtl/fp_classify.sv
// fp_classify: binary32 operand class flags, denormals count as zero
module fp_classify
  import fpu_pkg::*;
(
  input  logic [31:0] x,
  output logic        is_neg,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan
);
  logic [FP_EXP_W-1:0] e;
  logic [FP_FRAC_W-1:0] f;
  assign e = x[30:23];
  assign f = x[22:0];
  assign is_neg = x[31];
  assign is_zero = e == '0;
  assign is_inf = &e && f == '0;
  assign is_nan = &e && f != '0;
endmodule

// File: rtl/fdiv.sv
// fdiv: sequential binary32 divider, radix-2 restoring mantissa iteration
// FDIV_ROUND_EN selects round-to-nearest-even (26 iterations) instead of truncation (25).
module fdiv
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out
);
  localparam int N = FDIV_ITER;
  fdiv_state_t state, state_nx;
  logic sa, za, ia, na, sb, zb, ib, nb;
  logic accept, special, last, ge, hi, s;
  logic [31:0] spec_res, norm_res;
  logic [24:0] r, r_sub, r_nx;
  logic [23:0] mb;
  logic [N-1:0] q, q_nx;
  logic [4:0] cnt;
  logic [9:0] e0;
  logic signed [9:0] e;
  logic [22:0] fr, frac;
  fp_classify u_ca (.x(a), .is_neg(sa), .is_zero(za), .is_inf(ia), .is_nan(na));
  fp_classify u_cb (.x(b), .is_neg(sb), .is_zero(zb), .is_inf(ib), .is_nan(nb));
  assign accept = in_valid && in_ready;
  assign special = za | zb | ia | ib | na | nb;
  assign spec_res = (na | nb | (za & zb) | (ia & ib)) ? FP_QNAN :
                    (ia | zb) ? {sa ^ sb, FP_INF} : 32'h0;
  assign last = cnt == 5'(N - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = in_valid ? (special ? DONE : DIV) : IDLE;
      DIV: state_nx = last ? DONE : DIV;
      DONE: state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  always_comb begin
    ge = r >= {1'b0, mb};
    r_sub = ge ? r - {1'b0, mb} : r;
    r_nx = r_sub << 1;
    q_nx = {q[N-2:0], ge};
    hi = q_nx[N-1];
    fr = hi ? q_nx[N-2 -: 23] : q_nx[N-3 -: 23];
  end
`ifdef FDIV_ROUND_EN
  logic guard, sticky, up, carry;
  always_comb begin
    guard = hi ? q_nx[1] : q_nx[0];
    sticky = (r_nx != '0) | (hi & q_nx[0]);
    up = guard & (sticky | fr[0]);
    carry = up & (&fr);
    frac = fr + 23'(up);
    e = e0 + 10'(hi) + 10'(carry);
  end
`else
  always_comb begin
    frac = fr;
    e = e0 + 10'(hi);
  end
`endif
  assign norm_res = (e >= 10'sd255) ? {s, FP_INF} :
                    (e <= 10'sd0) ? 32'h0 : {s, e[7:0], frac};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r <= '0;
      mb <= '0;
      q <= '0;
      cnt <= '0;
      e0 <= '0;
      s <= 1'b0;
      out <= '0;
    end else if (accept) begin
      r <= {2'b01, a[22:0]};
      mb <= {1'b1, b[22:0]};
      q <= '0;
      cnt <= '0;
      e0 <= {2'b0, a[30:23]} - {2'b0, b[30:23]} + 10'(FP_BIAS - 1);
      s <= sa ^ sb;
      if (special) out <= spec_res;
    end else if (state == DIV) begin
      r <= r_nx;
      q <= q_nx;
      cnt <= cnt + 5'd1;
      if (last) out <= norm_res;
    end
endmodule

// File: tb/tb_fdiv.sv
// tb_fdiv: directed vector table plus backpressure and mid-operation reset sequences
module tb_fdiv;
`ifdef FDIV_ROUND_EN
  localparam int LN = 26;
  localparam bit RND = 1'b1;
`else
  localparam int LN = 25;
  localparam bit RND = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic in_ready, out_valid;
  logic [31:0] out;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  fdiv dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
            .out_valid(out_valid), .out_ready(out_ready), .out(out));
  typedef struct {
    string name;
    logic [31:0] a, b, q_t, q_r;
    bit sp;
  } vec_t;
  vec_t v[14];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic op(input string name, input logic [31:0] x, input logic [31:0] y,
                    input logic [31:0] exp, input int lat);
    int n;
    @(negedge clk);
    a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom; n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, " latency"}, n, lat);
    chk(name, out, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, " valid/ready after"}, {30'b0, out_valid, in_ready}, 32'd1);
    if (!out_valid && !in_ready) begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask
  initial begin
    int n;
    v[0]  = '{"6/2",      32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000, 0};
    v[1]  = '{"-6/2",     32'hC0C00000, 32'h40000000, 32'hC0400000, 32'hC0400000, 0};
    v[2]  = '{"1/3",      32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 32'h3EAAAAAB, 0};
    v[3]  = '{"1/1.5",    32'h3F800000, 32'h3FC00000, 32'h3F2AAAAA, 32'h3F2AAAAB, 0};
    v[4]  = '{"1/1",      32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 0};
    v[5]  = '{"ovf",      32'h7F000000, 32'h3F000000, 32'h7F800000, 32'h7F800000, 0};
    v[6]  = '{"unf",      32'h00800000, 32'h40000000, 32'h00000000, 32'h00000000, 0};
    v[7]  = '{"5/0",      32'h40A00000, 32'h00000000, 32'h7F800000, 32'h7F800000, 1};
    v[8]  = '{"-5/0",     32'hC0A00000, 32'h00000000, 32'hFF800000, 32'hFF800000, 1};
    v[9]  = '{"0/0",      32'h00000000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 1};
    v[10] = '{"inf/inf",  32'h7F800000, 32'h7F800000, 32'h7FC00000, 32'h7FC00000, 1};
    v[11] = '{"1/inf",    32'h3F800000, 32'h7F800000, 32'h00000000, 32'h00000000, 1};
    v[12] = '{"nan/1",    32'h7FC00001, 32'h3F800000, 32'h7FC00000, 32'h7FC00000, 1};
    v[13] = '{"-0/5",     32'h80000000, 32'h40A00000, 32'h00000000, 32'h00000000, 1};
    #1;
    chk("reset valid/ready", {30'b0, out_valid, in_ready}, 32'd1);
    chk("reset out", out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++)
      op(v[i].name, v[i].a, v[i].b, RND ? v[i].q_r : v[i].q_t, v[i].sp ? 0 : LN);
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp latency", n, LN);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = 32'h3F800000; b = 32'h3F800000;
      chk("bp out", out, 32'h40400000);
      chk("bp valid/ready", {30'b0, out_valid, in_ready}, 32'd2);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp release", {30'b0, out_valid, in_ready}, 32'd1);
    @(negedge clk);
    chk("bp no stray accept", {30'b0, out_valid, in_ready}, 32'd1);
    a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("mid busy", {30'b0, out_valid, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid reset valid/ready", {30'b0, out_valid, in_ready}, 32'd1);
    chk("mid reset out", out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    op("post reset 6/2", 32'h40C00000, 32'h40000000, 32'h40400000, LN);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
